// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: next-PC select codes
// and the default reset/exception vectors used by the control unit and bench.
package pc_pkg;

    typedef logic [2:0] pc_sel_t;

    localparam pc_sel_t PC_SEQ  = 3'd0;
    localparam pc_sel_t PC_BR   = 3'd1;
    localparam pc_sel_t PC_JMP  = 3'd2;
    localparam pc_sel_t PC_CALL = 3'd3;
    localparam pc_sel_t PC_RET  = 3'd4;
    localparam pc_sel_t PC_EXC  = 3'd5;
    localparam pc_sel_t PC_HOLD = 3'd6;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;
    localparam int          PC_INC       = 4;
    localparam int          PC_OFF_SHIFT = 2;
    localparam int          PC_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Request/status bundle between the control unit (master) and pc_gen (slave).
interface pc_gen_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);

    logic                          stall;
    logic                          branch;
    logic [ADDR_W-1:0]             offset;
    logic                          jump;
    logic                          call;
    logic                          ret;
    logic [ADDR_W-1:0]             target;
    logic                          exc;
    logic [ADDR_W-1:0]             ins_addr;
    logic [ADDR_W-1:0]             epc;
    logic [$clog2(RAS_DEPTH):0]    ras_count;
    logic                          ras_err;

    modport master (
        output stall, branch, offset, jump, call, ret, target, exc,
        input  ins_addr, epc, ras_count, ras_err
    );

    modport slave (
        input  stall, branch, offset, jump, call, ret, target, exc,
        output ins_addr, epc, ras_count, ras_err
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// underflow leaves the pointer alone; both raise a registered one-cycle err.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       err
);

    localparam int              PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_p0 [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_p0;
    logic [PTR_W:0]    cnt_p0;
    logic              err_p0;
    logic [PTR_W-1:0]  top_idx;
    logic              full;
    logic              empty;

    assign top_idx = wp_p0 - PTR_W'(1);
    assign full    = (cnt_p0 == FULL);
    assign empty   = (cnt_p0 == '0);

    // stage p0: storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem_p0[wp_p0] <= push_data;
        end
    end

    // stage p0: pointer, occupancy and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_p0  <= '0;
            cnt_p0 <= '0;
            err_p0 <= 1'b0;
        end else begin
            err_p0 <= 1'b0;
            if (pop) begin
                if (empty) begin
                    err_p0 <= 1'b1;
                end else begin
                    wp_p0  <= top_idx;
                    cnt_p0 <= cnt_p0 - (PTR_W+1)'(1);
                end
            end else if (push) begin
                wp_p0 <= wp_p0 + PTR_W'(1);
                if (full) begin
                    err_p0 <= 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + (PTR_W+1)'(1);
                end
            end
        end
    end

    assign top   = mem_p0[top_idx];
    assign count = cnt_p0;
    assign err   = err_p0;

endmodule

// File: rtl/pc_gen.sv
// Program counter with prioritised next-PC selection (exc > stall > ret >
// call > jump > branch > sequential), exception PC capture and a return stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INC       = PC_INC,
    parameter int                OFF_SHIFT = PC_OFF_SHIFT,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC),
    parameter int                RAS_DEPTH = PC_RAS_DEPTH
) (
    input logic      clk,
    input logic      reset,
    pc_gen_if.slave  bus
);

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    logic [ADDR_W-1:0]          pc_p0;
    logic [ADDR_W-1:0]          epc_p0;
    logic [ADDR_W-1:0]          next_pc;
    logic signed [ADDR_W-1:0]   off_s;
    pc_sel_t                    sel;
    logic                       ras_push;
    logic                       ras_pop;
    logic [ADDR_W-1:0]          ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;
    logic                       ras_err;

    function automatic logic [ADDR_W-1:0] f_seq(input logic [ADDR_W-1:0] pc);
        return pc + INC_V;
    endfunction

    // Shift wraps within ADDR_W, so high offset bits fall off silently.
    function automatic logic [ADDR_W-1:0] f_branch(
        input logic [ADDR_W-1:0]        pc,
        input logic signed [ADDR_W-1:0] off
    );
        logic signed [ADDR_W-1:0] scaled;
        scaled = off <<< OFF_SHIFT;
        return pc + INC_V + $unsigned(scaled);
    endfunction

    assign off_s = $signed(bus.offset);

    always_comb begin
        sel = PC_SEQ;
        if (bus.exc)         sel = PC_EXC;
        else if (bus.stall)  sel = PC_HOLD;
        else if (bus.ret)    sel = PC_RET;
        else if (bus.call)   sel = PC_CALL;
        else if (bus.jump)   sel = PC_JMP;
        else if (bus.branch) sel = PC_BR;
    end

    // An empty stack turns ret into a sequential step.
    always_comb begin
        next_pc = f_seq(pc_p0);
        case (sel)
            PC_EXC:  next_pc = EXC_VEC;
            PC_HOLD: next_pc = pc_p0;
            PC_RET:  next_pc = (ras_cnt != '0) ? ras_top : f_seq(pc_p0);
            PC_CALL: next_pc = bus.target;
            PC_JMP:  next_pc = bus.target;
            PC_BR:   next_pc = f_branch(pc_p0, off_s);
            default: next_pc = f_seq(pc_p0);
        endcase
    end

    assign ras_push = (sel == PC_CALL);
    assign ras_pop  = (sel == PC_RET);

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (f_seq(pc_p0)),
        .top       (ras_top),
        .count     (ras_cnt),
        .err       (ras_err)
    );

    // stage p0: architectural PC and exception PC
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0  <= RESET_VEC;
            epc_p0 <= '0;
        end else begin
            pc_p0 <= next_pc;
            if (sel == PC_EXC) begin
                epc_p0 <= pc_p0;
            end
        end
    end

    assign bus.ins_addr  = pc_p0;
    assign bus.epc       = epc_p0;
    assign bus.ras_count = ras_cnt;
    assign bus.ras_err   = ras_err;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized requests
// compared each cycle against a queue-based reference model.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    pc_gen_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH)) bus ();

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_err;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, e, s, rt, c, j, b, input logic [31:0] off, tgt);
        m_err = 1'b0;
        if (r) begin
            m_pc  = PC_RESET_VEC;
            m_epc = 32'h0;
            m_ras.delete();
        end else if (e) begin
            m_epc = m_pc;
            m_pc  = PC_EXC_VEC;
        end else if (s) begin
            m_pc = m_pc;
        end else if (rt) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = m_pc + 32'd4;
                m_err = 1'b1;
            end
        end else if (c) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_err = 1'b1;
            end
            m_pc = tgt;
        end else if (j) begin
            m_pc = tgt;
        end else if (b) begin
            m_pc = m_pc + 32'd4 + off * 32'd4;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: drive on the falling edge, compare #1 after the rising edge.
    task automatic step(input logic r, e, s, rt, c, j, b,
                        input logic [31:0] off, tgt, input string tag);
        @(negedge clk);
        reset      = r;
        bus.exc    = e;
        bus.stall  = s;
        bus.ret    = rt;
        bus.call   = c;
        bus.jump   = j;
        bus.branch = b;
        bus.offset = off;
        bus.target = tgt;
        model(r, e, s, rt, c, j, b, off, tgt);
        @(posedge clk);
        #1;
        chk({tag, ".pc"},  bus.ins_addr, m_pc);
        chk({tag, ".epc"}, bus.epc, m_epc);
        chk({tag, ".cnt"}, 32'(bus.ras_count), 32'(m_ras.size()));
        chk({tag, ".err"}, 32'(bus.ras_err), 32'(m_err));
    endtask

    task automatic seq(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, tag);
    endtask

    task automatic jmp(input logic [31:0] tgt, input string tag);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, tgt, tag);
    endtask

    task automatic call_to(input logic [31:0] tgt, input string tag);
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, tgt, tag);
    endtask

    task automatic ret_op(input string tag);
        step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.exc    = 1'b0;
        bus.stall  = 1'b0;
        bus.ret    = 1'b0;
        bus.call   = 1'b0;
        bus.jump   = 1'b0;
        bus.branch = 1'b0;
        bus.offset = '0;
        bus.target = '0;
        m_pc       = 32'h0;
        m_epc      = 32'h0;
        m_err      = 1'b0;

        // reset and free-running count
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "reset");
        chk("reset_pc_const", bus.ins_addr, 32'h0);
        seq("seq1");
        seq("seq2");
        seq("seq3");
        chk("seq3_const", bus.ins_addr, 32'd12);

        // branches: forward from 8, backward from 24
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "reset2");
        seq("s4");
        seq("s8");
        step(0, 0, 0, 0, 0, 0, 1, 32'd3, 32'h0, "br_fwd");
        chk("br_fwd_const", bus.ins_addr, 32'd24);
        step(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0, "br_back");
        chk("br_back_const", bus.ins_addr, 32'd20);

        // jump beats branch, then stall holds
        jmp(32'd16, "to16");
        step(0, 0, 0, 0, 0, 1, 1, 32'd5, 32'h100, "jmp_vs_br");
        chk("jmp_const", bus.ins_addr, 32'h100);
        step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, "stall1");
        step(0, 0, 1, 1, 1, 1, 1, 32'h1, 32'h900, "stall2");
        chk("stall_const", bus.ins_addr, 32'h100);

        // nested calls and returns, then underflow
        call_to(32'h200, "call1");
        call_to(32'h300, "call2");
        chk("call_cnt_const", 32'(bus.ras_count), 32'd2);
        ret_op("ret1");
        chk("ret1_const", bus.ins_addr, 32'h204);
        ret_op("ret2");
        chk("ret2_const", bus.ins_addr, 32'h104);
        ret_op("ret_under");
        chk("under_pc_const", bus.ins_addr, 32'h108);
        chk("under_err_const", 32'(bus.ras_err), 32'd1);
        seq("after_under");

        // ret beats call: no push happens
        call_to(32'h600, "rc_call");
        step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h700, "ret_vs_call");
        chk("ret_vs_call_cnt", 32'(bus.ras_count), 32'd0);

        // overflow: five calls from 0x40 to 0x40
        jmp(32'h40, "to40");
        for (int i = 0; i < 5; i++) call_to(32'h40, "ovf_call");
        chk("ovf_cnt_const", 32'(bus.ras_count), 32'd4);
        chk("ovf_err_const", 32'(bus.ras_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ret_op("ovf_ret");
            chk("ovf_ret_const", bus.ins_addr, 32'h44);
        end
        ret_op("ovf_under");
        chk("ovf_under_err", 32'(bus.ras_err), 32'd1);

        // exception wins over stall and call; reset after a call
        jmp(32'h4c, "to4c");
        call_to(32'h50, "pre_exc_call");
        step(0, 1, 1, 0, 1, 0, 0, 32'h0, 32'h999, "exc");
        chk("exc_pc_const", bus.ins_addr, 32'h80);
        chk("exc_epc_const", bus.epc, 32'h50);
        chk("exc_cnt_const", 32'(bus.ras_count), 32'd1);
        call_to(32'h300, "call_pre_rst");
        step(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h400, "rst_mid");
        chk("rst_cnt_const", 32'(bus.ras_count), 32'd0);
        ret_op("ret_after_rst");

        // wrap-around past all-ones
        jmp(32'hFFFF_FFFC, "to_top");
        seq("wrap");
        chk("wrap_const", bus.ins_addr, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r, e, s, rt, c, j, b;
            logic [31:0] off, tgt;
            r   = ($urandom_range(0, 99) < 2);
            e   = ($urandom_range(0, 99) < 5);
            s   = ($urandom_range(0, 99) < 10);
            rt  = ($urandom_range(0, 99) < 25);
            c   = ($urandom_range(0, 99) < 30);
            j   = ($urandom_range(0, 99) < 15);
            b   = ($urandom_range(0, 99) < 30);
            off = 32'($urandom_range(0, 127)) - 32'd64;
            if ($urandom_range(0, 9) == 0) off = $urandom;
            tgt = $urandom;
            step(r, e, s, rt, c, j, b, off, tgt, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the single-cycle CPU program counter.
- Holds the instruction address and selects the next PC from: sequential, branch offset, absolute jump, call/return, stall and exception redirect.
- Adds a small circular return-address stack (RAS) for call/return, plus an exception-PC capture register.
- Sits between the control unit/ALU branch-resolve logic and instruction memory; drives ins_addr directly.

Parameters:
- ADDR_W, 32, width of PC, offset, target and all stack entries.
- INC, 4, sequential increment in address units.
- OFF_SHIFT, 2, left shift applied to the branch offset before adding.
- RESET_VEC, 0, PC value loaded on reset.
- EXC_VEC, 32'h80, PC value loaded on an exception.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; all other requests ignored except exc.
- branch  in  1  take branch: next = pc + INC + (offset << OFF_SHIFT).
- offset  in  ADDR_W  signed branch offset (two's complement).
- jump  in  1  absolute jump: next = target.
- call  in  1  jump to target and push pc + INC onto the RAS.
- ret  in  1  pop the RAS; next = popped value.
- target  in  ADDR_W  absolute jump/call destination.
- exc  in  1  exception: next = EXC_VEC; epc <= pc.
- ins_addr  out  ADDR_W  current PC (registered).
- epc  out  ADDR_W  PC of the last excepting instruction.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_err  out  1  one-cycle pulse on RAS underflow or overflow.

Behaviour:
- Reset (sampled at posedge clk): ins_addr=RESET_VEC, epc=0, ras_count=0, ras_err=0, RAS pointer=0. RAS contents are don't-care. Reset overrides every other input in the same cycle.
- All updates occur on the rising clock edge. Next-PC selection is combinational from the current ins_addr; the new PC appears one cycle after its request is sampled.
- Priority, highest first: exc > stall > ret > call > jump > branch > sequential (pc + INC).
- Lower-priority requests in the same cycle are ignored and have no side effects; for example, a call losing to a ret does not push.
- Arithmetic is modulo 2^ADDR_W. Wrap-around past all-ones is legal and silent. offset is sign-extended conceptually; the shift drops its high bits.
- exc: ins_addr <= EXC_VEC, epc <= ins_addr. The RAS is untouched, and exc wins even over stall.
- stall: ins_addr, RAS and ras_count all hold; ras_err=0.
- call: pushes ins_addr + INC at the write pointer; pointer++; ras_count increments, saturating at RAS_DEPTH.
  - Overflow (call when ras_count==RAS_DEPTH) overwrites the oldest entry (circular) and pulses ras_err; ras_count stays RAS_DEPTH.
- ret with ras_count>0: next = the top entry; pointer--; ras_count--.
- ret with ras_count==0 (underflow): behaves as sequential (pc + INC), pulses ras_err, pointer unchanged.
- ras_err is registered: high exactly the cycle after the offending request, otherwise 0.
- Reset mid-operation (e.g. during a call sequence) clears the RAS state; no partial push survives.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC select encoding (PC_SEQ, PC_BR, PC_JMP, PC_CALL, PC_RET, PC_EXC, PC_HOLD);
  - the default vectors, so the control unit and the bench share them.
- One natural sub-module: pc_ras, the circular return stack.
  - Inputs: push, pop, push_data.
  - Outputs: top, count, err.
  - Parameters: ADDR_W, RAS_DEPTH.
  - pc_gen contains only the priority mux and the PC/EPC registers.

Test Plan:
- Reset then 3 free-running cycles -> ins_addr 0, 4, 8, 12; epc=0; ras_count=0.
- At pc=8, branch=1 with offset=3 -> next pc=8+4+12=24. With offset=-2 (32'hFFFFFFFE) at pc=24 -> next pc=20.
- At pc=16, jump=1 with branch=1 and target=0x100 -> pc=0x100 (jump beats branch). Then stall for 2 cycles -> pc holds at 0x100.
- Calls and returns: call to 0x200 from pc=0x100, then call to 0x300 from pc=0x200 -> ras_count=2.
  - First ret -> pc=0x204; second ret -> pc=0x104; ras_count=0.
  - Third ret -> pc=0x108 with a one-cycle ras_err pulse.
- Overflow: 5 successive calls to target=0x40 from pc=0x40 with default depth.
  - The 5th call pulses ras_err; ras_count stays 4.
  - 4 rets all return 0x44; a 5th ret underflows.
- Exception and reset interplay:
  - exc asserted together with stall and call at pc=0x50 -> pc=0x80, epc=0x50, ras_count unchanged.
  - Reset asserted in the cycle after a call -> pc=RESET_VEC and ras_count=0 the next cycle.
